// File: rtl/seq_detect_param_pkg.sv
// Shared definitions for the programmable serial pattern detector.
// Reset defaults reproduce the legacy fixed 101101 non-overlapping detector.
package seq_detect_pkg;

  localparam logic [5:0] DEF_PATTERN = 6'b101101;
  localparam int         DEF_LEN     = 6;
  localparam logic       DEF_OVERLAP = 1'b0;

  // What the detector does with the current cycle.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_SHIFT = 2'd1,
    ACT_LOAD  = 2'd2
  } act_e;

  // cfg_len must be able to hold the value MAX_LEN itself.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial stream, count control and match status between the input stage,
// the detector and the status/interrupt logic.
interface seq_detect_if #(
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             data_in;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in_valid,
    output data_in,
    output cnt_clr,
    input  match,
    input  match_cnt
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  cnt_clr,
    output match,
    output match_cnt
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector: compares the newest len
// accepted bits against pat, with overlapping or non-overlapping matching.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  seq_detect_if.slave        bus
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cfg_len_c;
  logic               ovl;
  logic               hit;
  act_e               act;

  // A config write takes priority and swallows any bit offered alongside it.
  always_comb begin
    act = ACT_HOLD;
    if (cfg_we) begin
      act = ACT_LOAD;
    end else if (bus.in_valid) begin
      act = ACT_SHIFT;
    end
  end

  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], bus.data_in};
    fill_n = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
    hit = (act == ACT_SHIFT) && (len != '0) && (fill_n >= len) &&
          (((hist_n ^ pat) & len_mask) == '0);
    cfg_len_c = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  end

  // Non-overlapping mode empties fill on a hit so later matches need fresh bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist      <= '0;
      fill      <= '0;
      bus.match <= 1'b0;
      pat       <= MAX_LEN'(DEF_PATTERN);
      len       <= LEN_W'(DEF_LEN);
      ovl       <= DEF_OVERLAP;
    end else begin
      case (act)
        ACT_LOAD: begin
          pat       <= cfg_pattern;
          len       <= cfg_len_c;
          ovl       <= cfg_overlap;
          hist      <= '0;
          fill      <= '0;
          bus.match <= 1'b0;
        end
        ACT_SHIFT: begin
          hist      <= hist_n;
          bus.match <= hit;
          fill      <= (hit && !ovl) ? '0 : fill_n;
        end
        default: begin
          bus.match <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .q     (bus.match_cnt)
  );

endmodule
